axis_position_integrator: RTL and testbench

- Parametrised successor to the single-axis position calculator: integrates a mode-selected speed into N_AXES independent position registers, one step per enabled cycle.
- Adds a valid/ready mode-command interface, per-axis direction, a charge/jump/cool-down warp sequence, wrap-around detection and a zero-all command.
- Sits in the spatial position path; its `pos` bus feeds the navigation display and collision logic.

---
 rtl/axis_position_integrator_if.sv | 30 +++
 rtl/axis_position_integrator.sv | 139 +++++++++++++
 tb/tb_axis_position_integrator.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_position_integrator_if.sv
// Mode-command handshake, warp control and position bus of the multi-axis
// position integrator.
interface axis_position_integrator_if #(
  parameter int W      = 16,
  parameter int VW     = 8,
  parameter int N_AXES = 3
);
  logic                  mode_valid;
  logic                  mode_ready;
  logic [3:0]            mode_sel;
  logic                  mode_err;
  logic                  step_en;
  logic [2*N_AXES-1:0]   dir;
  logic                  warp_req;
  logic                  warp_busy;
  logic [2:0]            state;
  logic [VW-1:0]         cur_speed;
  logic [W*N_AXES-1:0]   pos;
  logic [N_AXES-1:0]     wrapped;

  modport master (
    output mode_valid, mode_sel, step_en, dir, warp_req,
    input  mode_ready, mode_err, warp_busy, state, cur_speed, pos, wrapped
  );

  modport slave (
    input  mode_valid, mode_sel, step_en, dir, warp_req,
    output mode_ready, mode_err, warp_busy, state, cur_speed, pos, wrapped
  );
endinterface

// File: rtl/axis_position_integrator.sv
// Integrates a mode-selected speed into N_AXES position registers, with a
// charge/jump/cool-down warp sequence and sticky per-axis wrap flags.
module axis_position_integrator #(
  parameter int W          = 16,
  parameter int VW         = 8,
  parameter int N_AXES     = 3,
  parameter int ATTACK_V   = 4,
  parameter int DEFENSE_V  = 2,
  parameter int STEALTH_V  = 1,
  parameter int WARP_SHIFT = 4,
  parameter int CHARGE_CYC = 8,
  parameter int COOL_CYC   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  axis_position_integrator_if.slave     bus
);

  localparam int MAXC = (CHARGE_CYC > COOL_CYC) ? CHARGE_CYC : COOL_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int XW   = VW + WARP_SHIFT;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CRUISE = 3'd1,
    CHARGE = 3'd2,
    JUMP   = 3'd3,
    COOL   = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [VW-1:0]                speed_q, speed_d;
  logic                         err_q, err_d;
  logic [N_AXES-1:0][W-1:0]     pos_q, pos_d;
  logic [N_AXES-1:0]            wrap_q, wrap_d;

  logic                         ready;
  logic                         accept;
  logic                         move;
  logic [XW-1:0]                warp_full;
  logic [W-1:0]                 delta;

  assign ready     = !rst && (state_q == IDLE || state_q == CRUISE);
  assign accept    = bus.mode_valid && ready;
  assign move      = (state_q == CRUISE && bus.step_en) || (state_q == JUMP);
  assign warp_full = XW'(speed_q) << WARP_SHIFT;
  assign delta     = (state_q == JUMP) ? W'(warp_full) : W'(speed_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    speed_d = speed_q;
    err_d   = 1'b0;
    pos_d   = pos_q;
    wrap_d  = wrap_q;

    // Carry out of pos+delta happens exactly when pos > ~delta.
    if (move) begin
      for (int unsigned i = 0; i < N_AXES; i++) begin
        case (bus.dir[2*i +: 2])
          2'b01: begin
            pos_d[i] = pos_q[i] + delta;
            if (pos_q[i] > ~delta) wrap_d[i] = 1'b1;
          end
          2'b10: begin
            pos_d[i] = pos_q[i] - delta;
            if (pos_q[i] < delta) wrap_d[i] = 1'b1;
          end
          default: ;
        endcase
      end
    end

    // The zero command comes after the step so it overrides a same-cycle step.
    case (state_q)
      IDLE, CRUISE: begin
        if (accept) begin
          case (bus.mode_sel)
            4'b0001: begin
              pos_d   = '0;
              wrap_d  = '0;
              speed_d = '0;
              state_d = IDLE;
            end
            4'b0010: begin speed_d = VW'(ATTACK_V);  state_d = CRUISE; end
            4'b0100: begin speed_d = VW'(DEFENSE_V); state_d = CRUISE; end
            4'b1000: begin speed_d = VW'(STEALTH_V); state_d = CRUISE; end
            default: err_d = 1'b1;
          endcase
        end else if (state_q == CRUISE && bus.warp_req) begin
          state_d = CHARGE;
          cnt_d   = CW'(CHARGE_CYC - 1);
        end
      end
      CHARGE: begin
        if (!bus.warp_req)     state_d = CRUISE;
        else if (cnt_q == '0)  state_d = JUMP;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      JUMP: begin
        state_d = COOL;
        cnt_d   = CW'(COOL_CYC - 1);
      end
      COOL: begin
        if (cnt_q == '0) state_d = CRUISE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      speed_q <= '0;
      err_q   <= 1'b0;
      pos_q   <= '0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      speed_q <= speed_d;
      err_q   <= err_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.mode_ready = ready;
  assign bus.mode_err   = err_q;
  assign bus.warp_busy  = (state_q == CHARGE) || (state_q == JUMP) || (state_q == COOL);
  assign bus.state      = state_q;
  assign bus.cur_speed  = speed_q;
  assign bus.pos        = pos_q;
  assign bus.wrapped    = wrap_q;

endmodule

// File: tb/tb_axis_position_integrator.sv
// Directed bench for axis_position_integrator: a phase/elapsed-cycle model
// checked every cycle, plus literal expectations at scenario milestones.
module tb_axis_position_integrator;
  localparam int W = 16;
  localparam int VW = 8;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_position_integrator_if #(.W(W), .VW(VW), .N_AXES(N)) bus();

  axis_position_integrator #(
    .W(W), .VW(VW), .N_AXES(N),
    .ATTACK_V(4), .DEFENSE_V(2), .STEALTH_V(1),
    .WARP_SHIFT(4), .CHARGE_CYC(8), .COOL_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: phase 0 idle, 1 cruise, 2 charge, 3 jump, 4 cool; el counts the
  // cycles already spent in the current charge/cool phase (1-based).
  int  ph, el, spd;
  int  mp [N];
  bit  mw [N];
  bit  merr;
  bit  m_ok = 1'b0;

  function automatic void model_move(input int d_in);
    int d;
    d = d_in % 65536;
    for (int i = 0; i < N; i++) begin
      case (bus.dir[2*i +: 2])
        2'b01: begin
          if (mp[i] + d >= 65536) mw[i] = 1'b1;
          mp[i] = (mp[i] + d) % 65536;
        end
        2'b10: begin
          if (mp[i] < d) mw[i] = 1'b1;
          mp[i] = (mp[i] - d + 65536) % 65536;
        end
        default: ;
      endcase
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; el = 0; spd = 0; merr = 1'b0; m_ok = 1'b1;
      for (int i = 0; i < N; i++) begin mp[i] = 0; mw[i] = 1'b0; end
    end else if (m_ok) begin
      merr = 1'b0;
      if (ph == 1 && bus.step_en) model_move(spd);
      if (ph == 3) model_move(spd * 16);
      if (ph <= 1) begin
        if (bus.mode_valid) begin
          if (bus.mode_sel == 4'b0001) begin
            ph = 0; spd = 0;
            for (int i = 0; i < N; i++) begin mp[i] = 0; mw[i] = 1'b0; end
          end
          else if (bus.mode_sel == 4'b0010) begin spd = 4; ph = 1; end
          else if (bus.mode_sel == 4'b0100) begin spd = 2; ph = 1; end
          else if (bus.mode_sel == 4'b1000) begin spd = 1; ph = 1; end
          else merr = 1'b1;
        end else if (ph == 1 && bus.warp_req) begin
          ph = 2; el = 1;
        end
      end else if (ph == 2) begin
        if (!bus.warp_req) ph = 1;
        else if (el == 8) ph = 3;
        else el++;
      end else if (ph == 3) begin
        ph = 4; el = 1;
      end else begin
        if (el == 4) ph = 1;
        else el++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("pos%0d", i), 32'(bus.pos[W*i +: W]), mp[i]);
        chk($sformatf("wrapped%0d", i), 32'(bus.wrapped[i]), 32'(mw[i]));
      end
      chk("state", 32'(bus.state), ph);
      chk("cur_speed", 32'(bus.cur_speed), spd);
      chk("mode_err", 32'(bus.mode_err), 32'(merr));
      chk("warp_busy", 32'(bus.warp_busy), 32'(ph >= 2));
      chk("mode_ready", 32'(bus.mode_ready), 32'(!rst && ph <= 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cmd(input logic [3:0] sel);
    bus.mode_valid = 1'b1;
    bus.mode_sel   = sel;
    tick();
    bus.mode_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.mode_valid = 1'b0;
    bus.mode_sel   = 4'b0000;
    bus.step_en    = 1'b0;
    bus.dir        = '0;
    bus.warp_req   = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_pos", 32'(bus.pos == '0), 1);
    chk("rst_speed", 32'(bus.cur_speed), 0);
    rst = 1'b0;

    // attack: axis0 '+', five steps of 4
    bus.dir = 6'b000001;
    cmd(4'b0010);
    bus.step_en = 1'b1;
    repeat (5) tick();
    bus.step_en = 1'b0;
    chk("atk_pos0", 32'(bus.pos[15:0]), 20);
    chk("atk_pos12", 32'(bus.pos[47:16]), 0);
    chk("atk_speed", 32'(bus.cur_speed), 4);
    chk("atk_state", 32'(bus.state), 1);

    // wrap: defense, axis1 '-' from zero
    cmd(4'b0001);
    cmd(4'b0100);
    bus.dir = 6'b001000;
    bus.step_en = 1'b1;
    tick();
    chk("wrap_pos1", 32'(bus.pos[31:16]), 32'hFFFE);
    chk("wrap_flag1", 32'(bus.wrapped[1]), 1);
    repeat (2) tick();
    bus.step_en = 1'b0;
    chk("wrap_pos1b", 32'(bus.pos[31:16]), 32'hFFFA);
    chk("wrap_sticky", 32'(bus.wrapped), 32'b010);
    cmd(4'b0001);
    chk("zero_pos", 32'(bus.pos == '0), 1);
    chk("zero_wrap", 32'(bus.wrapped), 0);

    // full warp: stealth, axis2 '+'
    cmd(4'b1000);
    bus.dir = 6'b010000;
    bus.warp_req = 1'b1;
    tick();
    chk("warp_busy_rise", 32'(bus.warp_busy), 1);
    n = 0;
    while (bus.state == 3'd2 && n < 20) begin n++; tick(); end
    chk("charge_cycles", n, 8);
    chk("jump_state", 32'(bus.state), 3);
    tick();
    chk("jump_pos2", 32'(bus.pos[47:32]), 16);
    n = 0;
    while (bus.state == 3'd4 && n < 20) begin n++; tick(); end
    chk("cool_cycles", n, 4);
    chk("cool_exit", 32'(bus.state), 1);

    // abort: warp_req still high retriggers; drop on third charge cycle
    repeat (3) tick();
    chk("abort_in_charge", 32'(bus.state), 2);
    bus.warp_req = 1'b0;
    tick();
    chk("abort_state", 32'(bus.state), 1);
    chk("abort_pos2", 32'(bus.pos[47:32]), 16);

    // non-one-hot command
    cmd(4'b0110);
    chk("bad_err", 32'(bus.mode_err), 1);
    chk("bad_speed", 32'(bus.cur_speed), 1);
    tick();
    chk("bad_err_clr", 32'(bus.mode_err), 0);

    // command held through COOL
    bus.warp_req = 1'b1;
    tick();
    n = 0;
    while (bus.state == 3'd2 && n < 20) begin n++; tick(); end
    bus.warp_req = 1'b0;
    bus.mode_valid = 1'b1;
    bus.mode_sel = 4'b0010;
    tick();
    n = 0;
    while (bus.state == 3'd4 && n < 20) begin n++; tick(); end
    chk("cool_hold_speed", 32'(bus.cur_speed), 1);
    chk("cool_hold_ready", 32'(bus.mode_ready), 1);
    tick();
    bus.mode_valid = 1'b0;
    chk("cool_cmd_speed", 32'(bus.cur_speed), 4);
    chk("warp2_pos2", 32'(bus.pos[47:32]), 32);

    // reset during JUMP
    bus.warp_req = 1'b1;
    tick();
    n = 0;
    while (bus.state == 3'd2 && n < 20) begin n++; tick(); end
    chk("mid_jump", 32'(bus.state), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.warp_req = 1'b0;
    chk("mid_rst_pos", 32'(bus.pos == '0), 1);
    chk("mid_rst_state", 32'(bus.state), 0);
    chk("mid_rst_busy", 32'(bus.warp_busy), 0);
    bus.step_en = 1'b1;
    repeat (2) tick();
    bus.step_en = 1'b0;
    chk("idle_step_pos", 32'(bus.pos == '0), 1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
